fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter width, default 16, data word width; SHALL match the attached FIFO's width.
REQ-002 Parameter n_req, default 4, number of write requesters (2..8).
REQ-003 Parameter burst_len, default 4, maximum beats per grant (1..16).
REQ-004 Port clk  input  1  single clock, all state updates on posedge clk.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port req  input  n_req  per-requester write request, level, held until ack or withdrawn.
REQ-007 Port req_data  input  n_req x width  per-requester write word, valid while req high.
REQ-008 Port fifo_full  input  1  full flag from FIFO.
REQ-009 Port gnt  output  n_req  one-hot registered grant, at most one bit high.
REQ-010 Port ack  output  n_req  one-hot combinational beat acceptance (word taken this cycle).
REQ-011 Port fifo_write  output  1  FIFO write strobe, combinational.
REQ-012 Port fifo_data_in  output  width  word driven to FIFO, combinational.
REQ-013 Port owner  output  clog2(n_req)  index of current grant holder, registered.
REQ-014 Port busy  output  1  high while in BURST state.

Function
REQ-015 FSM SHALL have two states: IDLE (arbitrate) and BURST (transfer).
REQ-016 IDLE: if any req bit high, the next owner SHALL be the first requester with req high searching from last_owner+1 upward, modulo n_req; next cycle state=BURST, gnt=onehot(owner), beat_cnt=0.
REQ-017 IDLE with req all-zero: state SHALL stay IDLE, gnt=0.
REQ-018 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gnt high.
REQ-019 In BURST, accept = req[owner] && !fifo_full; fifo_write=accept, ack[owner]=accept, all other ack bits 0.
REQ-020 fifo_data_in SHALL equal req_data[owner] while in BURST, 0 in IDLE.
REQ-021 Each accepted beat SHALL increment beat_cnt (clog2(burst_len)+1 bits, no wrap within a burst).
REQ-022 BURST SHALL end (next state IDLE, gnt=0, last_owner=owner) when accept occurs with beat_cnt==burst_len-1, or when req[owner] is low.
REQ-023 fifo_full high in BURST SHALL stall: no write, no ack, beat_cnt held, grant held indefinitely.
REQ-024 Requests from non-owners during BURST SHALL be ignored until the next IDLE cycle; no preemption.
REQ-025 fifo_write SHALL never assert while fifo_full is high; the arbiter SHALL never cause a FIFO overflow.
REQ-026 Every burst SHALL be followed by at least one IDLE cycle (one arbitration bubble).

Reset
REQ-027 On rst high at posedge clk: state=IDLE, gnt=0, owner=0, beat_cnt=0, busy=0, last_owner=n_req-1 (requester 0 has first priority).
REQ-028 rst asserted mid-burst SHALL abort the burst; the partially written beats remain in the FIFO, and no further ack occurs.
REQ-029 While rst is high, ack and fifo_write SHALL be 0 regardless of req.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and default parameter constants.
REQ-031 Round-robin search SHALL be a combinational sub-module rr_pick (inputs req, last_owner; outputs found, next_owner).
REQ-032 The top level SHALL contain the FSM, owner/last_owner/beat_cnt registers and the output mux.

Verification
REQ-033 Reset, then req=0001 with fifo_full=0 held 6 cycles -> gnt=0001 at cycle 1; beats at cycles 1-4 with ack=0001 each; IDLE at cycle 5; re-grant at cycle 6.
REQ-034 req=1111 held continuously -> grant order 0,1,2,3,0; each burst 4 beats, with 1 IDLE cycle between bursts.
REQ-035 Owner 2 mid-burst after 2 beats, fifo_full=1 for 3 cycles -> fifo_write=0 and ack=0 for 3 cycles, gnt held; remaining 2 beats follow, then release.
REQ-036 Owner 1 drops req after 1 beat -> BURST ends next cycle, last_owner=1; a waiting req=1001 grants requester 3.
REQ-037 rst pulsed during beat 2 of owner 0 -> next cycle gnt=0, busy=0, owner=0; after rst low, req=0110 grants requester 1.
REQ-038 Attach synchronous_FIFO depth 16, with 4 requesters writing tagged data and reads disabled -> exactly 16 words accepted, no write while full; drained order matches the grant sequence.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Defaults describe a 4-requester, 16-bit, 4-beat-burst arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side signal bundle of the write arbiter.
// The arbiter uses the master view; the requesters, FIFO and bench use the slave view.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int n_req = DEF_N_REQ
);
    localparam int OW = $clog2(n_req);

    logic [n_req-1:0]            req;
    logic [n_req-1:0][width-1:0] req_data;
    logic                        fifo_full;
    logic [n_req-1:0]            gnt;
    logic [n_req-1:0]            ack;
    logic                        fifo_write;
    logic [width-1:0]            fifo_data_in;
    logic [OW-1:0]               owner;
    logic                        busy;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_write, fifo_data_in, owner, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_write, fifo_data_in, owner, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin search: first requester with req high, starting just above
// last_owner and wrapping modulo n_req (last_owner itself is tried last).
module rr_pick #(
    parameter int n_req = 4
) (
    input  logic [n_req-1:0]         req,
    input  logic [$clog2(n_req)-1:0] last_owner,
    output logic                     found,
    output logic [$clog2(n_req)-1:0] next_owner
);
    localparam int OW = $clog2(n_req);

    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        next_owner = last_owner;
        for (int i = 1; i <= n_req; i++) begin
            idx = (int'(last_owner) + i) % n_req;
            if (!found && req[idx]) begin
                found      = 1'b1;
                next_owner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter funnelling n_req write requesters into one FIFO.
// A grant holds for up to burst_len accepted beats and stalls while the FIFO is full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width     = DEF_WIDTH,
    parameter int n_req     = DEF_N_REQ,
    parameter int burst_len = DEF_BURST_LEN
) (
    input logic                 clk,
    input logic                 rst,
    fifo_write_arbiter_if.master bus
);
    localparam int OW = $clog2(n_req);
    localparam int BW = $clog2(burst_len) + 1;

    arb_state_e       state_q, state_d;
    logic [n_req-1:0] gnt_q, gnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_owner_q, last_owner_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;

    logic             found;
    logic [OW-1:0]    next_owner;
    logic             owner_req;
    logic             accept;
    logic             last_beat;
    logic [n_req-1:0] ack_d;

    rr_pick #(.n_req(n_req)) u_rr_pick (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .found      (found),
        .next_owner (next_owner)
    );

    assign owner_req = bus.req[owner_q];
    // Gating on rst keeps a reset cycle from acking a beat mid-burst.
    assign accept    = (state_q == BURST) && owner_req && !bus.fifo_full && !rst;
    assign last_beat = (beat_cnt_q == BW'(burst_len - 1));

    always_comb begin
        ack_d = '0;
        if (accept) ack_d[owner_q] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d             = BURST;
                    owner_d             = next_owner;
                    gnt_d[next_owner]   = 1'b1;
                    beat_cnt_d          = '0;
                end
            end
            BURST: begin
                if (!owner_req || (accept && last_beat)) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OW'(n_req - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state_q == BURST);
    assign bus.ack          = ack_d;
    assign bus.fifo_write   = accept;
    assign bus.fifo_data_in = (state_q == BURST) ? bus.req_data[owner_q] : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: 4 requesters, 16-bit data, 4-beat bursts.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.width(16), .n_req(4)) bus ();

    fifo_write_arbiter #(.width(16), .n_req(4), .burst_len(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_data();
        for (int r = 0; r < 4; r++) bus.req_data[r] = 16'(16'hA000 + 16'(r * 16'h0100) + 16'(r));
    endtask

    logic [15:0] fq[$];
    logic [11:0] seq [4];
    int          full_writes;

    initial begin
        bus.req = '0;
        bus.fifo_full = 1'b0;
        set_data();

        // Reset state, with requests asserted while rst is high
        rst = 1'b1;
        tick();
        bus.req = 4'b1111;
        settle();
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_fwrite", 32'(bus.fifo_write), 32'h0);
        tick();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);

        // Single requester 0: grant at cycle 1, beats 1-4, IDLE at 5, re-grant at 6
        do_reset();
        bus.req = 4'b0001;
        settle();
        chk("c0_gnt", 32'(bus.gnt), 32'h0);
        chk("c0_fwrite", 32'(bus.fifo_write), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("single_gnt", 32'(bus.gnt), 32'h1);
            chk("single_ack", 32'(bus.ack), 32'h1);
            chk("single_data", 32'(bus.fifo_data_in), 32'hA000);
        end
        tick();
        chk("c5_gnt", 32'(bus.gnt), 32'h0);
        chk("c5_busy", 32'(bus.busy), 32'h0);
        chk("c5_fwrite", 32'(bus.fifo_write), 32'h0);
        chk("c5_data", 32'(bus.fifo_data_in), 32'h0);
        tick();
        chk("c6_gnt", 32'(bus.gnt), 32'h1);

        // All four requesting: grant order 0,1,2,3,0 with one IDLE bubble between
        do_reset();
        bus.req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("rr_gnt", 32'(bus.gnt), 32'(1 << (b % 4)));
                chk("rr_owner", 32'(bus.owner), 32'(b % 4));
                chk("rr_ack", 32'(bus.ack), 32'(1 << (b % 4)));
                chk("rr_data", 32'(bus.fifo_data_in), 32'(16'hA000 + (b % 4) * 16'h0101));
            end
            tick();
            chk("rr_bubble_busy", 32'(bus.busy), 32'h0);
            chk("rr_bubble_fwrite", 32'(bus.fifo_write), 32'h0);
        end

        // Owner 2 stalled by fifo_full for 3 cycles after 2 beats
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("st_b1_ack", 32'(bus.ack), 32'h4);
        tick();
        chk("st_b2_ack", 32'(bus.ack), 32'h4);
        tick();
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("st_full_fwrite", 32'(bus.fifo_write), 32'h0);
            chk("st_full_ack", 32'(bus.ack), 32'h0);
            chk("st_full_gnt", 32'(bus.gnt), 32'h4);
            tick();
        end
        bus.fifo_full = 1'b0;
        settle();
        chk("st_b3_ack", 32'(bus.ack), 32'h4);
        tick();
        chk("st_b4_ack", 32'(bus.ack), 32'h4);
        tick();
        chk("st_release_gnt", 32'(bus.gnt), 32'h0);
        chk("st_release_busy", 32'(bus.busy), 32'h0);

        // Owner 1 withdraws after 1 beat; waiting 1001 must go to requester 3
        do_reset();
        bus.req = 4'b0010;
        tick();
        chk("wd_b1_ack", 32'(bus.ack), 32'h2);
        tick();
        bus.req = 4'b1001;
        settle();
        chk("wd_drop_ack", 32'(bus.ack), 32'h0);
        chk("wd_drop_fwrite", 32'(bus.fifo_write), 32'h0);
        tick();
        chk("wd_idle_busy", 32'(bus.busy), 32'h0);
        chk("wd_idle_gnt", 32'(bus.gnt), 32'h0);
        tick();
        chk("wd_next_gnt", 32'(bus.gnt), 32'h8);
        chk("wd_next_owner", 32'(bus.owner), 32'h3);

        // Reset pulsed during beat 2 of owner 0
        do_reset();
        bus.req = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("ar_ack", 32'(bus.ack), 32'h0);
        chk("ar_fwrite", 32'(bus.fifo_write), 32'h0);
        tick();
        rst = 1'b0;
        bus.req = 4'b0110;
        settle();
        chk("ar_gnt", 32'(bus.gnt), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_owner", 32'(bus.owner), 32'h0);
        tick();
        chk("ar_regrant", 32'(bus.gnt), 32'h2);

        // Depth-16 FIFO with reads disabled: exactly 16 words, in grant order
        do_reset();
        fq.delete();
        full_writes = 0;
        for (int r = 0; r < 4; r++) seq[r] = '0;
        bus.req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            bus.fifo_full = (fq.size() >= 16);
            for (int r = 0; r < 4; r++) bus.req_data[r] = {4'(r), seq[r]};
            settle();
            if (bus.fifo_write) begin
                if (bus.fifo_full) full_writes++;
                else fq.push_back(bus.fifo_data_in);
            end
            for (int r = 0; r < 4; r++) if (bus.ack[r]) seq[r]++;
            tick();
        end
        chk("fifo_count", 32'(fq.size()), 32'd16);
        chk("fifo_full_writes", 32'(full_writes), 32'd0);
        for (int k = 0; k < 16 && k < fq.size(); k++)
            chk("fifo_order", 32'(fq[k]), 32'({4'(k / 4), 12'(k % 4)}));
        chk("fifo_stall_gnt", 32'(bus.gnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
